// File: rtl/axi4_ring_wr_dma.sv
// Write-side DMA that drains a stream FIFO into a power-of-two ring in memory.
// AXI4 INCR bursts, bounded outstanding bursts, sticky B error, fill interrupt.
module axi4_ring_wr_dma #(
  parameter int AW              = 49,
  parameter int DW              = 128,
  parameter int IDW             = 6,
  parameter int BURST_BEATS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LVL_W           = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic [AW-1:0]    cfg_baseaddr,
  input  logic [31:0]      cfg_size,
  input  logic [31:0]      cfg_intr_thresh,
  input  logic             cfg_err_clr,
  input  logic [31:0]      host_rdptr,
  output logic [31:0]      wrptr,
  output logic             busy,
  output logic             err,
  output logic [AW-1:0]    err_addr,
  output logic             intr,
  input  logic [DW-1:0]    src_tdata,
  input  logic             src_tvalid,
  output logic             src_tready,
  input  logic [LVL_W-1:0] src_level,
  output logic [IDW-1:0]   m_awid,
  output logic [AW-1:0]    m_awaddr,
  output logic [7:0]       m_awlen,
  output logic [2:0]       m_awsize,
  output logic [1:0]       m_awburst,
  output logic             m_awlock,
  output logic [3:0]       m_awcache,
  output logic [2:0]       m_awprot,
  output logic [3:0]       m_awqos,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [DW-1:0]    m_wdata,
  output logic [DW/8-1:0]  m_wstrb,
  output logic             m_wlast,
  output logic             m_wvalid,
  input  logic             m_wready,
  input  logic [IDW-1:0]   m_bid,
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready
);

  localparam int BB = BURST_BEATS * DW / 8;
  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int OW = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   aw_ptr;
  logic [OW-1:0] owed;
  logic [3:0]    outst;
  logic [BW-1:0] beat;

  logic          owing;
  logic          w_fire;
  logic          b_fire;
  logic          b_ok;
  logic          ring_ok;
  logic          lvl_ok;
  logic          outst_ok;
  logic          aw_go;
  logic          thr_hit;
  logic [31:0]   wr_next;
  logic [31:0]   ring_off;
  logic [31:0]   wr_off;
  logic          unused_b;

  assign m_awid    = '0;
  assign m_awlen   = 8'(BURST_BEATS - 1);
  assign m_awsize  = 3'($clog2(DW / 8));
  assign m_awburst = 2'b01;
  assign m_awlock  = 1'b0;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_awqos   = 4'b0000;
  assign m_wstrb   = '1;
  assign m_bready  = 1'b1;
  assign m_wdata   = src_tdata;

  assign busy     = (state != IDLE);
  assign owing    = (owed != '0);
  assign m_wvalid = src_tvalid & owing;
  assign src_tready = m_wready & owing;
  assign w_fire   = src_tvalid & m_wready & owing;
  assign m_wlast  = (beat == BW'(BURST_BEATS - 1));

  assign b_fire   = m_bvalid;
  assign b_ok     = ~m_bresp[1];
  assign wr_next  = wrptr + 32'(BB);
  assign thr_hit  = (cfg_intr_thresh != 32'd0) &&
                    ((wr_next - host_rdptr) >= cfg_intr_thresh);
  assign ring_off = aw_ptr & (cfg_size - 32'd1);
  assign wr_off   = wrptr & (cfg_size - 32'd1);
  assign unused_b = ^{m_bid, m_bresp[0]};

  // Modulo-2^32 distance keeps the ring check valid across pointer wrap.
  assign ring_ok  = (cfg_size - (aw_ptr - host_rdptr)) >= 32'(BB);
  assign lvl_ok   = 32'(src_level) >= 32'(owed) + 32'(BURST_BEATS);
  assign outst_ok = outst < 4'(MAX_OUTSTANDING);
  assign aw_go    = (state == RUN) && cfg_enable && !err &&
                    ring_ok && lvl_ok && outst_ok &&
                    (!m_awvalid || m_awready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      aw_ptr    <= '0;
      owed      <= '0;
      outst     <= '0;
      beat      <= '0;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      wrptr     <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
      intr      <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (cfg_enable && !err) state <= RUN;
        RUN:     if (!cfg_enable || err) state <= DRAIN;
        DRAIN:   if (outst == '0 && owed == '0 && !m_awvalid)
                   state <= IDLE;
        default: state <= IDLE;
      endcase

      if (aw_go) begin
        m_awvalid <= 1'b1;
        m_awaddr  <= cfg_baseaddr + AW'(ring_off);
        aw_ptr    <= aw_ptr + 32'(BB);
      end else if (m_awready) begin
        m_awvalid <= 1'b0;
      end

      owed  <= owed + (aw_go ? OW'(BURST_BEATS) : OW'(0))
                    - (w_fire ? OW'(1) : OW'(0));
      outst <= outst + {3'b000, aw_go} - {3'b000, b_fire};

      if (w_fire)
        beat <= m_wlast ? '0 : beat + BW'(1);

      intr <= 1'b0;
      if (b_fire && b_ok) begin
        wrptr <= wr_next;
        intr  <= thr_hit;
      end

      // Bursts retire in order, so wrptr points at the failing burst.
      if (b_fire && !b_ok && !err) begin
        err      <= 1'b1;
        err_addr <= cfg_baseaddr + AW'(wr_off);
        intr     <= 1'b1;
      end else if (cfg_err_clr && state == IDLE) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_ring_wr_dma.sv
// Randomized bench for axi4_ring_wr_dma with a transaction-level
// ring/stream/response model.
module tb_axi4_ring_wr_dma;

  localparam int AW    = 49;
  localparam int DW    = 128;
  localparam int IDW   = 6;
  localparam int BEATS = 2;
  localparam int MAXO  = 4;
  localparam int LVL_W = 10;
  localparam int BB    = BEATS * DW / 8;
  localparam logic [AW-1:0] BASE = 49'h1_0000_2000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_enable;
  logic [AW-1:0]    cfg_baseaddr;
  logic [31:0]      cfg_size;
  logic [31:0]      cfg_intr_thresh;
  logic             cfg_err_clr;
  logic [31:0]      host_rdptr;
  logic [31:0]      wrptr;
  logic             busy;
  logic             err;
  logic [AW-1:0]    err_addr;
  logic             intr;
  logic [DW-1:0]    src_tdata;
  logic             src_tvalid;
  logic             src_tready;
  logic [LVL_W-1:0] src_level;
  logic [IDW-1:0]   m_awid;
  logic [AW-1:0]    m_awaddr;
  logic [7:0]       m_awlen;
  logic [2:0]       m_awsize;
  logic [1:0]       m_awburst;
  logic             m_awlock;
  logic [3:0]       m_awcache;
  logic [2:0]       m_awprot;
  logic [3:0]       m_awqos;
  logic             m_awvalid;
  logic             m_awready;
  logic [DW-1:0]    m_wdata;
  logic [DW/8-1:0]  m_wstrb;
  logic             m_wlast;
  logic             m_wvalid;
  logic             m_wready;
  logic [IDW-1:0]   m_bid;
  logic [1:0]       m_bresp;
  logic             m_bvalid;
  logic             m_bready;

  always #5 clk = ~clk;

  axi4_ring_wr_dma #(
    .AW(AW), .DW(DW), .IDW(IDW), .BURST_BEATS(BEATS),
    .MAX_OUTSTANDING(MAXO), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_baseaddr(cfg_baseaddr),
    .cfg_size(cfg_size), .cfg_intr_thresh(cfg_intr_thresh),
    .cfg_err_clr(cfg_err_clr), .host_rdptr(host_rdptr),
    .wrptr(wrptr), .busy(busy), .err(err), .err_addr(err_addr),
    .intr(intr),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid),
    .src_tready(src_tready), .src_level(src_level),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock),
    .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  int checks;
  int fails;
  int aw_hs;
  int b_cnt;
  int w_beats;
  int avail;
  int b_budget;
  int err_at;
  int intr_cnt;
  int saved;
  bit rnd;
  bit follow;
  bit clr_req;
  bit clr_idle;
  bit m_err;
  bit exp_intr;
  logic [31:0]   m_aw;
  logic [31:0]   m_wr;
  logic [AW-1:0] m_eaddr;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int n);
    return {4{32'(n) ^ 32'hA5C3_0000}};
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    cfg_enable  = 1'b0;
    cfg_err_clr = 1'b0;
    src_tvalid  = 1'b0;
    src_tdata   = '0;
    src_level   = '0;
    m_awready   = 1'b0;
    m_wready    = 1'b0;
    m_bvalid    = 1'b0;
    m_bresp     = 2'b00;
    m_bid       = '0;
    repeat (3) @(posedge clk);
    aw_hs = 0; b_cnt = 0; w_beats = 0; avail = 0;
    b_budget = 1000000; err_at = -1; intr_cnt = 0;
    follow = 0; clr_req = 0; clr_idle = 0;
    m_err = 0; exp_intr = 0;
    m_aw = '0; m_wr = '0; m_eaddr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle();
    logic [31:0] lvl;
    logic [31:0] free;
    int issued;
    @(negedge clk);
    chk("intr", intr, exp_intr);
    if (intr) intr_cnt++;
    chk("wrptr", wrptr, m_wr);
    chk("err", err, m_err);
    if (m_err) chk("err_addr", err_addr, m_eaddr);
    exp_intr = 0;

    lvl = avail - w_beats;
    src_level  = (lvl > 32'd1023) ? 10'd1023 : lvl[LVL_W-1:0];
    src_tvalid = (lvl != 0) && (!rnd || $urandom_range(3) != 0);
    src_tdata  = data_of(w_beats);
    m_awready  = !rnd || $urandom_range(2) != 0;
    m_wready   = !rnd || $urandom_range(3) != 0;
    m_bvalid   = (b_cnt < aw_hs) && (b_cnt < b_budget) &&
                 ((b_cnt + 1) * BEATS <= w_beats) &&
                 (!rnd || $urandom_range(1) == 1);
    m_bresp    = (b_cnt == err_at) ? 2'b10 : 2'b00;
    cfg_err_clr = clr_req;
    if (follow && $urandom_range(3) == 0) host_rdptr = m_wr;
    #1;

    issued = aw_hs + (m_awvalid ? 1 : 0);
    chk("wsync", m_wvalid && m_wready, src_tvalid && src_tready);
    if (src_tvalid && src_tready) begin
      chk("wdata", m_wdata, data_of(w_beats));
      chk("wlast", m_wlast, (w_beats % BEATS) == BEATS - 1);
      chk("w_ahead", w_beats < issued * BEATS, 1);
      w_beats++;
    end
    if (m_awvalid && m_awready) begin
      free = cfg_size - (m_aw - host_rdptr);
      chk("awaddr", m_awaddr,
          cfg_baseaddr + AW'(m_aw & (cfg_size - 32'd1)));
      chk("awlen", m_awlen, BEATS - 1);
      chk("ring_free", free >= BB, 1);
      m_aw += BB;
      aw_hs++;
      chk("outst", aw_hs - b_cnt <= MAXO, 1);
    end
    if (m_bvalid) begin
      chk("bready", m_bready, 1);
      if (!m_bresp[1]) begin
        m_wr += BB;
        if (cfg_intr_thresh != 0 &&
            (m_wr - host_rdptr) >= cfg_intr_thresh)
          exp_intr = 1;
      end else if (!m_err) begin
        m_err    = 1;
        m_eaddr  = cfg_baseaddr + AW'(m_wr & (cfg_size - 32'd1));
        exp_intr = 1;
      end
      b_cnt++;
    end
    if (clr_req && clr_idle) m_err = 0;
    clr_req = 0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rnd    = 0;
    cfg_baseaddr    = BASE;
    cfg_size        = 32'd4096;
    cfg_intr_thresh = 32'd0;
    host_rdptr      = 32'd0;
    do_reset();
    #1;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_tready", src_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_intr", intr, 0);
    chk("rst_wrptr", wrptr, 0);

    // Four bursts from eight beats, all readies high.
    avail = 8;
    cfg_enable = 1;
    repeat (40) cycle();
    chk("basic_aws", aw_hs, 4);
    chk("basic_wrptr", wrptr, 128);
    chk("basic_busy", busy, 1);
    cfg_enable = 0;
    for (int i = 0; i < 50 && busy; i++) cycle();
    chk("basic_idle", busy, 0);

    // Ring of 64 bytes fills after two bursts.
    rnd = 1;
    cfg_size = 32'd64;
    do_reset();
    avail = 1000000;
    cfg_enable = 1;
    repeat (40) cycle();
    chk("ring_aws", aw_hs, 2);
    host_rdptr = 32'd32;
    repeat (40) cycle();
    chk("ring_aws2", aw_hs, 3);

    // Read pointer just below 2^32: free space computed modulo 2^32.
    do_reset();
    host_rdptr = 32'hFFFF_FFE0;
    avail = 1000000;
    cfg_enable = 1;
    repeat (40) cycle();
    chk("wrap_aws", aw_hs, 1);
    host_rdptr = 32'h0000_0000;
    repeat (40) cycle();
    chk("wrap_aws2", aw_hs, 2);
    host_rdptr = 32'h0000_0020;
    repeat (40) cycle();
    chk("wrap_aws3", aw_hs, 3);

    // Outstanding limit with B withheld, then one B released.
    cfg_size = 32'd4096;
    do_reset();
    host_rdptr = 32'd0;
    avail = 1000000;
    b_budget = 0;
    cfg_enable = 1;
    repeat (40) cycle();
    chk("outst_aws", aw_hs, MAXO);
    b_budget = 1;
    repeat (20) cycle();
    chk("outst_aws2", aw_hs, MAXO + 1);
    chk("outst_b", b_cnt, 1);

    // SLVERR on the second burst, third held back to keep DRAIN busy.
    do_reset();
    avail = 6;
    b_budget = 2;
    err_at = 1;
    cfg_enable = 1;
    for (int i = 0; i < 200 && !(m_err && aw_hs == 3); i++) cycle();
    chk("err_seen", m_err && aw_hs == 3, 1);
    repeat (3) cycle();
    clr_req = 1;
    clr_idle = 0;
    cycle();
    chk("err_drain_busy", busy, 1);
    cycle();
    b_budget = 1000000;
    for (int i = 0; i < 200 && busy; i++) cycle();
    chk("err_idle", busy, 0);
    repeat (5) cycle();
    chk("err_no_restart", busy, 0);
    chk("err_wrptr", wrptr, 64);
    cfg_enable = 0;
    clr_req = 1;
    clr_idle = 1;
    cycle();
    cycle();
    chk("err_cleared", err, 0);
    chk("err_intr_cnt", intr_cnt, 1);

    // Threshold of 64 bytes over two bursts: one pulse.
    do_reset();
    cfg_intr_thresh = 32'd64;
    avail = 4;
    cfg_enable = 1;
    repeat (60) cycle();
    chk("thr_intr_cnt", intr_cnt, 1);
    chk("thr_wrptr", wrptr, 64);

    // Long stream with a consuming host, then enable dropped.
    do_reset();
    cfg_intr_thresh = 32'd96;
    avail = 1000000;
    follow = 1;
    cfg_enable = 1;
    repeat (150) cycle();
    cfg_enable = 0;
    for (int i = 0; i < 300 && busy; i++) cycle();
    chk("drop_idle", busy, 0);
    chk("drop_drained", b_cnt, aw_hs);
    chk("drop_progress", aw_hs > 8, 1);
    saved = aw_hs;
    repeat (20) cycle();
    chk("drop_no_aw", aw_hs, saved);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/axi4_ring_wr_dma.md
# axi4_ring_wr_dma

Parametrised write-side DMA engine that drains a PL stream FIFO into a power-of-two ring buffer in PS memory through an AXI4 master write port. It generalises the fixed two-beat write path of the current controller: configurable burst length and outstanding-transaction limit, an explicit run/drain/idle state machine, B-response error capture and a fill-threshold interrupt. The block sits between the accelerator output FIFO and the PS HP port, with its configuration and pointers exported to the slave register file.

## Interface
- AW, 49, AXI address width
- DW, 128, AXI data width; power of two, 32..1024
- IDW, 6, AXI ID width; all IDs driven 0
- BURST_BEATS, 2, beats per burst; power of two, 1..256
- MAX_OUTSTANDING, 4, maximum AW bursts issued without B response; 1..15
- LVL_W, 10, width of source FIFO level input

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_enable  in  1  run request; 0 requests drain
- cfg_baseaddr  in  AW  ring base address, aligned to cfg_size
- cfg_size  in  32  ring size in bytes; power of two, ≥ burst bytes
- cfg_intr_thresh  in  32  fill threshold in bytes; 0 disables threshold interrupt
- cfg_err_clr  in  1  one-cycle pulse, clears err
- host_rdptr  in  32  free-running byte count consumed by software
- wrptr  out  32  free-running byte count committed (B OKAY)
- busy  out  1  state ≠ IDLE
- err  out  1  sticky B error flag
- err_addr  out  AW  address of first failed burst
- intr  out  1  one-cycle interrupt pulse
- src_tdata  in  DW  stream data; src_tvalid in 1; src_tready out 1
- src_level  in  LVL_W  beats currently held in source FIFO
- m_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid out, m_awready in
- m_wdata/wstrb/wlast/wvalid out, m_wready in
- m_bid/bresp/bvalid in, m_bready out

## Operation
- BB = BURST_BEATS·DW/8. Constants: awlen = BURST_BEATS−1, awsize = log2(DW/8), awburst INCR, wstrb all ones, lock/cache/prot/qos 0, bready = 1.
- Internal: aw_ptr (32b, bytes issued), owed (beats issued by AW not yet sent on W), outst (AW issued, B not received), beat counter for wlast.
- States: IDLE → RUN when cfg_enable=1 and err=0. RUN → DRAIN when cfg_enable=0 or err=1. DRAIN → IDLE when outst=0, owed=0, awvalid=0.
- Issue (RUN only, awvalid=0 or accepted this cycle): cfg_size − (aw_ptr − host_rdptr) ≥ BB; src_level − owed ≥ BURST_BEATS; outst < MAX_OUTSTANDING.
- On issue: awaddr ← cfg_baseaddr + (aw_ptr & (cfg_size−1)); aw_ptr += BB; owed += BURST_BEATS; outst += 1. awaddr and awvalid held stable until awready.
- W: wvalid = src_tvalid & (owed ≠ 0); src_tready = m_wready & (owed ≠ 0); wdata = src_tdata. Each beat owed −1; wlast on beat BURST_BEATS−1 of each burst.
- B: outst −1. bresp OKAY/EXOKAY → wrptr += BB. SLVERR/DECERR → wrptr unchanged; if err=0, set err and latch err_addr = cfg_baseaddr + (wrptr & (cfg_size−1)). Issue stops; outstanding bursts still complete.
- cfg_err_clr clears err only in IDLE; ignored otherwise.
- intr pulses on: err 0→1; or a B OKAY where fill = wrptr_new − host_rdptr ≥ cfg_intr_thresh ≠ 0.
- All pointer arithmetic is 32-bit modulo; wrap of aw_ptr, wrptr, host_rdptr across 2^32 is transparent.

## Timing
- Reset values: awvalid 0, wvalid 0, src_tready 0, wrptr 0, busy 0, err 0, err_addr 0, intr 0, aw_ptr/owed/outst 0, state IDLE. Reset mid-burst abandons the transaction; no further handshakes after the reset edge.
- awvalid asserts the cycle after the issue condition is met; back-to-back bursts with no bubble when awready held high.
- wrptr, err, intr update the cycle after the B handshake.
- AW issue and B in the same cycle: outst unchanged. AW issue and W beat same cycle: owed += BURST_BEATS−1.
- Ring full (free < BB): no issue until host_rdptr advances; resumes the cycle after the condition clears.
- cfg_enable dropped while awvalid=1: the pending AW completes; no new AW.

## Test plan
- DW=128, BURST_BEATS=2, size 4096, src_level 8, ready always 1 → 4 bursts at base+0,32,64,96; wrptr=128 after last B.
- Ring full: host_rdptr 0, size 64, BURST_BEATS=2 → two bursts then stall; host_rdptr←32 → third burst at base+0.
- MAX_OUTSTANDING=2, bvalid withheld → exactly 2 AWs; release one B → third AW next cycle.
- bresp SLVERR on second burst → err=1, err_addr=base+32, intr one cycle, wrptr stays 32, state DRAIN→IDLE; cfg_err_clr in IDLE clears err.
- wrptr/host_rdptr near 0xFFFF_FFE0, size 64 → wrap to 0x0000_0000 with correct addresses and continued issue.
- cfg_intr_thresh=64, BB=32 → intr on second OKAY only; cfg_enable drop mid-stream → busy clears after last B.
